// File: rtl/alu_req_scheduler.sv
// Round-robin front end that shares the structural ALU between NUM_REQ requesters:
// grants one request, issues a one-hot unit enable, waits for the unit flag and returns the result.
module alu_req_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RES_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]          req_fun,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [1:0]                    alu_fun,
  output logic                          arith_en,
  output logic                          logic_en,
  output logic                          cmp_en,
  output logic                          shift_en,
  input  logic [RES_WIDTH-1:0]          alu_result,
  input  logic                          alu_flag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [RES_WIDTH-1:0]          rsp_data,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_id;
  logic [CW-1:0]         r_cnt;

  logic                  w_any;
  logic [IDW-1:0]        w_idx;
  logic [IDW-1:0]        w_pick;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [3:0]            w_fun;

  // First set request searching upward from r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_fun = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_pick == IDW'(k)) begin
        w_a   = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        w_b   = req_b[k*DATA_WIDTH +: DATA_WIDTH];
        w_fun = req_fun[k*4 +: 4];
      end
    end
  end

  // gnt must pulse in the same IDLE cycle the request is picked, so it is decoded, not registered.
  assign gnt  = (rst && r_state == S_IDLE && w_any) ? (NUM_REQ'(1) << w_pick) : '0;
  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      arith_en  <= 1'b0;
      logic_en  <= 1'b0;
      cmp_en    <= 1'b0;
      shift_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_pick;
            alu_a   <= w_a;
            alu_b   <= w_b;
            alu_fun <= w_fun[1:0];
            {shift_en, cmp_en, logic_en, arith_en} <= 4'b0001 << w_fun[3:2];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          {shift_en, cmp_en, logic_en, arith_en} <= 4'b0000;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The flag is tested first so a result on the last WAIT cycle beats the timeout.
          if (alu_flag) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_rr_ptr  <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
